// File: rtl/sram_burst_master_if.sv
// Single-port SRAM port bundle: chip select, output enable, address,
// active-low write request, write data and registered read data.
interface single_port_ram_intf #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
);
    logic              cs;
    logic              oe;
    logic [ADDR_W-1:0] addr;
    logic              W_req;
    logic [DATA_W-1:0] W_data;
    logic [DATA_W-1:0] R_data;

    modport master (output cs, oe, addr, W_req, W_data, input R_data);
    modport slave  (input cs, oe, addr, W_req, W_data, output R_data);
endinterface

// File: rtl/sram_burst_master.sv
// Burst initiator for the activation-buffer SRAM: one command becomes a run of single-word
// reads (to a 2-entry skid FIFO / stream) or writes (from a stream). Optional macro: SRAM_BURST_WRAP_EN.
module sram_burst_master #(
    parameter int          ADDR_W    = 18,
    parameter int          DATA_W    = 16,
    parameter int          LEN_W     = 18,
    parameter int unsigned MAX_WORDS = 196608
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              wr_mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    single_port_ram_intf.master mem
);
    localparam int SUM_W = ((ADDR_W > LEN_W) ? ADDR_W : LEN_W) + 1;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_RD_DRAIN, S_WR, S_FIN} state_t;
    state_t state, state_nxt;

    logic [ADDR_W-1:0] addr_q, addr_inc;
    logic [LEN_W-1:0]  remain;
    logic              err_q;
    logic [DATA_W-1:0] fifo [2];
    logic              head, tail;
    logic [1:0]        count;
    logic              inflight;
    logic              pop, rd_issue, wr_issue, issue, last_issue, range_bad;
    logic [2:0]        occ_after;

`ifdef SRAM_BURST_WRAP_EN
    assign range_bad = (SUM_W'(base_addr) >= SUM_W'(MAX_WORDS)) || (SUM_W'(length) > SUM_W'(MAX_WORDS));
    assign addr_inc  = (addr_q == ADDR_W'(MAX_WORDS - 1)) ? '0 : addr_q + ADDR_W'(1);
`else
    logic [SUM_W-1:0] end_sum;
    // end_sum is one past the last word; it must not pass the populated top
    assign end_sum   = SUM_W'(base_addr) + SUM_W'(length);
    assign range_bad = (SUM_W'(base_addr) >= SUM_W'(MAX_WORDS)) || (end_sum > SUM_W'(MAX_WORDS));
    assign addr_inc  = addr_q + ADDR_W'(1);
`endif

    assign rd_valid  = (count != 2'd0);
    assign rd_data   = fifo[head];
    assign pop       = rd_valid & rd_ready;
    assign tail      = head ^ count[0];
    // Slots still claimed after this cycle's pop; a read may issue while below 2
    assign occ_after = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};

    assign wr_ready   = (state == S_WR);
    assign rd_issue   = (state == S_RD) && (occ_after < 3'd2);
    assign wr_issue   = wr_ready & wr_valid;
    assign issue      = rd_issue | wr_issue;
    assign last_issue = issue && (remain == LEN_W'(1));

    assign mem.cs     = issue;
    assign mem.W_req  = ~wr_issue;
    assign mem.oe     = inflight;
    assign mem.addr   = addr_q;
    assign mem.W_data = wr_issue ? wr_data : '0;

    assign busy = (state == S_RD) || (state == S_RD_DRAIN) || (state == S_WR);
    assign done = (state == S_FIN);
    assign err  = (state == S_FIN) && err_q;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    if (length == '0 || range_bad) state_nxt = S_FIN;
                    else if (wr_mode)              state_nxt = S_WR;
                    else                           state_nxt = S_RD;
                end
            end
            S_RD:       if (last_issue) state_nxt = S_RD_DRAIN;
            S_RD_DRAIN: if (occ_after == 3'd0) state_nxt = S_FIN;
            S_WR:       if (last_issue) state_nxt = S_FIN;
            S_FIN:      state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            addr_q   <= '0;
            remain   <= '0;
            err_q    <= 1'b0;
            head     <= 1'b0;
            count    <= 2'd0;
            inflight <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && start) begin
                addr_q <= base_addr;
                remain <= length;
                err_q  <= (length != '0) && range_bad;
            end else if (issue) begin
                addr_q <= addr_inc;
                remain <= remain - LEN_W'(1);
            end
            // Read data appears one cycle after the issue cycle
            inflight <= rd_issue;
            if (inflight) fifo[tail] <= mem.R_data[DATA_W-1:0];
            if (pop) head <= ~head;
            count <= count + {1'b0, inflight} - {1'b0, pop};
        end
    end
endmodule

// File: tb/tb_sram_burst_master.sv
// Scoreboard bench for sram_burst_master with a behavioural registered-read SRAM.
module tb_sram_burst_master;
    localparam int ADDR_W = 18, DATA_W = 16, LEN_W = 18;

    logic clk = 1'b0, rst = 1'b1;
    logic start = 1'b0, wr_mode = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [LEN_W-1:0]  length = '0;
    logic busy, done, err, rd_valid, wr_ready;
    logic rd_ready = 1'b0, wr_valid = 1'b0;
    logic [DATA_W-1:0] rd_data, wr_data = '0;

    always #5 clk = ~clk;

    single_port_ram_intf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();

    sram_burst_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .MAX_WORDS(196608)) dut (
        .clk(clk), .rst(rst), .start(start), .wr_mode(wr_mode), .base_addr(base_addr),
        .length(length), .busy(busy), .done(done), .err(err), .rd_data(rd_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .wr_data(wr_data), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .mem(mem_if)
    );

    logic [15:0] sram [0:262143];
    initial for (int i = 0; i < 262144; i++) sram[i] <= 16'hA000 + i[15:0];

    always @(posedge clk) begin
        if (mem_if.cs) begin
            if (!mem_if.W_req) sram[mem_if.addr] <= mem_if.W_data;
            else               mem_if.R_data <= sram[mem_if.addr];
        end
    end

    int checks = 0, errors = 0, cyc = 0;
    int cs_count = 0, done_cnt = 0, done_cyc = 0, outstanding = 0, max_out = 0;
    logic done_err = 1'b0;
    int pop_cycs[$];
    logic [15:0] exp_q[$];
    logic [17:0] rlog[$];
    logic [33:0] wlog[$];
    logic mon_pop;
    logic [15:0] mon_e;

    function automatic logic [15:0] pat_word(input logic [17:0] a);
        return 16'hA000 + a[15:0];
    endfunction

    // Monitor: samples 2 time units after the falling edge, inputs are stable by then
    always @(negedge clk) begin
        #2;
        mon_pop = rd_valid && rd_ready;
        if (mon_pop) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: got %h, no word expected", rd_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (rd_data !== mon_e) begin
                    errors++;
                    $display("FAIL rd_data: got %h, expected %h", rd_data, mon_e);
                end
            end
            pop_cycs.push_back(cyc);
        end
        if (mem_if.cs === 1'b1) begin
            cs_count++;
            checks++;
            if (mem_if.W_req) begin
                rlog.push_back(mem_if.addr);
                if (outstanding - (mon_pop ? 1 : 0) >= 2) begin
                    errors++;
                    $display("FAIL rd_issue_rule: issue with %0d outstanding, pop=%0d", outstanding, mon_pop);
                end
                outstanding++;
            end else begin
                wlog.push_back({mem_if.addr, mem_if.W_data});
                if (!(wr_valid && wr_ready)) begin
                    errors++;
                    $display("FAIL wr_no_handshake: write at %h without handshake", mem_if.addr);
                end
            end
        end
        if (mon_pop) outstanding--;
        if (outstanding > max_out) max_out = outstanding;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            done_err = err;
        end
        if (err && !done) begin
            checks++; errors++;
            $display("FAIL err_without_done: err=%b done=%b", err, done);
        end
        if (rst) outstanding = 0;
        cyc++;
    end

    task automatic clr_logs();
        cs_count = 0; max_out = 0;
        rlog.delete(); wlog.delete(); pop_cycs.delete();
    endtask

    task automatic send_cmd(input logic wr, input logic [17:0] base, input logic [17:0] len, output int sc);
        @(negedge clk);
        start = 1'b1; wr_mode = wr; base_addr = base; length = len; sc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit timeout);
        int d0 = done_cnt;
        timeout = 1'b1;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk); #3;
            if (done_cnt != d0) begin timeout = 1'b0; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #3;
        checks++;
        if ({busy, done, err, rd_valid, wr_ready, mem_if.cs, mem_if.oe, mem_if.W_req} !== 8'b0000_0001) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, expected 00000001",
                     {busy, done, err, rd_valid, wr_ready, mem_if.cs, mem_if.oe, mem_if.W_req});
        end
        checks++;
        if (mem_if.addr !== 18'h0 || mem_if.W_data !== 16'h0) begin
            errors++;
            $display("FAIL reset_bus: addr=%h wdata=%h, expected 0/0", mem_if.addr, mem_if.W_data);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_read_basic();
        int sc; bit to;
        clr_logs();
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(pat_word(18'h00010 + 18'(i)));
        send_cmd(1'b0, 18'h00010, 18'd4, sc);
        #3;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL rd1_busy: got %b, expected 1", busy); end
        wait_done(40, to);
        checks++;
        if (to) begin errors++; $display("FAIL rd1_timeout: done not seen, expected done"); end
        checks++;
        if (pop_cycs.size() != 4 || pop_cycs[3] - pop_cycs[0] != 3) begin
            errors++; $display("FAIL rd1_consecutive: %0d pops, expected 4 in consecutive cycles", pop_cycs.size());
        end else begin
            checks++;
            if (done_cyc != pop_cycs[3] + 1) begin
                errors++; $display("FAIL rd1_done_time: done at %0d, expected %0d", done_cyc, pop_cycs[3] + 1);
            end
        end
        checks++;
        if (done_err !== 1'b0 || cs_count != 4 || exp_q.size() != 0) begin
            errors++; $display("FAIL rd1_summary: err=%b cs=%0d left=%0d, expected 0/4/0", done_err, cs_count, exp_q.size());
        end
    endtask

    task automatic test_read_backpressure();
        int sc; bit to;
        clr_logs();
        rd_ready = 1'b0;
        for (int i = 0; i < 8; i++) exp_q.push_back(pat_word(18'h00100 + 18'(i)));
        send_cmd(1'b0, 18'h00100, 18'd8, sc);
        to = 1'b1;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            rd_ready = ~rd_ready;
            #3;
            if (done) begin to = 1'b0; break; end
        end
        rd_ready = 1'b0;
        checks++;
        if (to) begin errors++; $display("FAIL rd2_timeout: done not seen, expected done"); end
        checks++;
        if (exp_q.size() != 0 || pop_cycs.size() != 8 || cs_count != 8) begin
            errors++; $display("FAIL rd2_counts: left=%0d pops=%0d cs=%0d, expected 0/8/8", exp_q.size(), pop_cycs.size(), cs_count);
        end
        checks++;
        if (max_out > 2) begin errors++; $display("FAIL rd2_occupancy: max %0d, expected <=2", max_out); end
    endtask

    task automatic test_write_gapped();
        int sc, idx = 0, k = 0; bit to;
        logic [15:0] wdat [4] = '{16'h5A00, 16'h5A11, 16'h5A22, 16'h5A33};
        logic [33:0] wexp[$];
        logic [33:0] got;
        clr_logs();
        send_cmd(1'b1, 18'h17FFE, 18'd4, sc);
        to = 1'b1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            wr_valid = ((k % 3) != 1);
            wr_data  = (idx < 4) ? wdat[idx] : 16'h0;
            k++;
            #1;
            if (wr_valid && wr_ready) begin
                wexp.push_back({18'h17FFE + 18'(idx), wdat[idx]});
                idx++;
            end
            #2;
            if (done) begin to = 1'b0; break; end
        end
        wr_valid = 1'b0;
        checks++;
        if (to || idx != 4) begin errors++; $display("FAIL wr3_handshakes: %0d handshakes timeout=%b, expected 4/0", idx, to); end
        checks++;
        if (wlog.size() != 4) begin
            errors++; $display("FAIL wr3_count: %0d writes, expected 4", wlog.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                got = wlog[i];
                checks++;
                if (got !== wexp[i]) begin
                    errors++; $display("FAIL wr3_write%0d: got %h/%h, expected %h/%h", i, got[33:16], got[15:0], wexp[i][33:16], wexp[i][15:0]);
                end
            end
        end
        clr_logs();
        rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(wdat[i]);
        send_cmd(1'b0, 18'h17FFE, 18'd4, sc);
        wait_done(40, to);
        rd_ready = 1'b0;
        checks++;
        if (to || exp_q.size() != 0) begin errors++; $display("FAIL wr3_readback: left=%0d timeout=%b, expected 0/0", exp_q.size(), to); end
    endtask

    task automatic test_range();
        int sc; bit to;
        logic [17:0] wa [4] = '{18'h2FFFE, 18'h2FFFF, 18'h00000, 18'h00001};
        clr_logs();
        rd_ready = 1'b1;
`ifdef SRAM_BURST_WRAP_EN
        for (int i = 0; i < 4; i++) exp_q.push_back(pat_word(wa[i]));
`endif
        send_cmd(1'b0, 18'h2FFFE, 18'd4, sc);
        wait_done(40, to);
        checks++;
        if (to) begin errors++; $display("FAIL rng_timeout: done not seen, expected done"); end
`ifdef SRAM_BURST_WRAP_EN
        checks++;
        if (done_err !== 1'b0 || rlog.size() != 4 || exp_q.size() != 0) begin
            errors++; $display("FAIL rng_wrap: err=%b reads=%0d left=%0d, expected 0/4/0", done_err, rlog.size(), exp_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rlog[i] !== wa[i]) begin errors++; $display("FAIL rng_wrap_addr%0d: got %h, expected %h", i, rlog[i], wa[i]); end
            end
        end
`else
        checks++;
        if (done_err !== 1'b1 || cs_count != 0) begin
            errors++; $display("FAIL rng_reject: err=%b cs=%0d, expected 1/0", done_err, cs_count);
        end
`endif
        clr_logs();
        for (int i = 0; i < 4; i++) exp_q.push_back(pat_word(18'h2FFFC + 18'(i)));
        send_cmd(1'b0, 18'h2FFFC, 18'd4, sc);
        wait_done(40, to);
        checks++;
        if (to || done_err !== 1'b0 || cs_count != 4 || exp_q.size() != 0) begin
            errors++; $display("FAIL rng_top_fit: err=%b cs=%0d left=%0d, expected 0/4/0", done_err, cs_count, exp_q.size());
        end
        clr_logs();
        send_cmd(1'b0, 18'h30000, 18'd1, sc);
        wait_done(10, to);
        checks++;
        if (to || done_err !== 1'b1 || cs_count != 0) begin
            errors++; $display("FAIL rng_bad_base: err=%b cs=%0d timeout=%b, expected 1/0/0", done_err, cs_count, to);
        end
        rd_ready = 1'b0;
    endtask

    task automatic test_len0_and_reset();
        int sc, d0; bit to;
        clr_logs();
        send_cmd(1'b0, 18'h00040, 18'd0, sc);
        wait_done(10, to);
        checks++;
        if (to || done_cyc - sc < 1 || done_cyc - sc > 2 || done_err !== 1'b0 || cs_count != 0) begin
            errors++; $display("FAIL len0: delay=%0d err=%b cs=%0d timeout=%b, expected 1..2/0/0/0", done_cyc - sc, done_err, cs_count, to);
        end
        clr_logs();
        rd_ready = 1'b0;
        send_cmd(1'b0, 18'h00200, 18'd8, sc);
        repeat (4) @(negedge clk);
        #3;
        checks++;
        if (busy !== 1'b1 || rd_valid !== 1'b1 || cs_count != 2) begin
            errors++; $display("FAIL stall_fill: busy=%b valid=%b cs=%0d, expected 1/1/2", busy, rd_valid, cs_count);
        end
        d0 = done_cnt;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        #3;
        checks++;
        if ({busy, done, err, rd_valid, wr_ready, mem_if.cs, mem_if.oe, mem_if.W_req} !== 8'b0000_0001 ||
            mem_if.addr !== 18'h0 || mem_if.W_data !== 16'h0) begin
            errors++; $display("FAIL mid_reset: ctrl=%b addr=%h, expected 00000001/0",
                               {busy, done, err, rd_valid, wr_ready, mem_if.cs, mem_if.oe, mem_if.W_req}, mem_if.addr);
        end
        exp_q.delete();
        clr_logs();
        repeat (6) @(negedge clk);
        #3;
        checks++;
        if (done_cnt != d0 || cs_count != 0) begin
            errors++; $display("FAIL post_reset_quiet: done pulses=%0d cs=%0d, expected 0/0", done_cnt - d0, cs_count);
        end
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_read_backpressure();
        test_write_gapped();
        test_range();
        test_len0_and_reset();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected finish");
        $fatal(1, "timeout");
    end
endmodule
